mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single main-memory port between the instruction cache (read-only line refills) and the data cache (line refills and single-word stores). Sits between both cache FSMs and the memory interface, sequences each transaction end to end (address phase, data beats, completion pulse), and applies round-robin fairness when both caches miss in the same cycle.

## Interface
- WORD, 32, data/address width
- LINE_WORDS, 4, words per refill burst (power of two, >=2)
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- i_req_valid  in  1  ICache refill request; held until i_req_ready
- i_req_addr  in  WORD  ICache miss address; stable while i_req_valid
- i_req_ready  out  1  one-cycle completion pulse to ICache
- i_rdata  out  WORD  refill beat data to ICache
- i_rdata_valid  out  1  i_rdata carries a valid beat
- d_req_valid  in  1  DCache request; held until d_req_ready
- d_req_wr  in  1  1 = single-word store, 0 = line refill
- d_req_addr  in  WORD  DCache address
- d_req_wdata  in  WORD  store data
- d_req_ready  out  1  one-cycle completion pulse to DCache
- d_rdata  out  WORD  refill beat data to DCache
- d_rdata_valid  out  1  d_rdata carries a valid beat
- mem_valid  out  1  address-phase request to memory
- mem_wr  out  1  request is a store
- mem_addr  out  WORD  request address
- mem_wdata  out  WORD  store data
- mem_ready  in  1  memory accepts address phase (and store) this cycle
- mem_rvalid  in  1  memory returns one read beat
- mem_rdata  in  WORD  read beat data

## Operation
- States: IDLE, REQ, RDATA, DONE.
- IDLE: sample i_req_valid/d_req_valid. None -> stay. One -> grant it. Both -> grant the requester not in last_grant. On grant: latch grant, wr (0 for ICache), addr, wdata; update last_grant; go REQ.
- last_grant resets to ICache, so DCache wins the first tie.
- REQ: mem_valid=1, mem_wr=latched wr, mem_wdata=latched wdata. mem_addr = latched addr for stores; latched addr with low log2(LINE_WORDS*WORD/8) bits cleared for refills. Hold until mem_ready. mem_ready & wr -> DONE; mem_ready & !wr -> RDATA with beat counter=0.
- RDATA: each mem_rvalid forwards mem_rdata to granted requester's rdata with its rdata_valid=1 (combinational from mem_rvalid, state, grant); counter increments. Beat with counter==LINE_WORDS-1 -> DONE.
- DONE: assert granted requester's req_ready for exactly one cycle; -> IDLE. Requester drops valid the following cycle, so IDLE never re-grants a finished request.
- Non-granted requester's ready/rdata_valid stay 0; its valid may rise or stay high at any time and is served in a later IDLE.
- mem_rvalid outside RDATA and mem_ready outside REQ are ignored.
- Counter width log2(LINE_WORDS); it never wraps within a burst, reset to 0 on entry to RDATA.

## Timing
- Reset (rst=0 at an edge): state IDLE, counter 0, last_grant ICache; all outputs 0 (mem_valid, mem_wr, mem_addr, mem_wdata, both ready, both rdata_valid). rdata outputs may mirror mem_rdata but rdata_valid is 0.
- Reset mid-transaction aborts it; no ready pulse is issued; later beats ignored.
- Request seen at IDLE in cycle t -> mem_valid=1 in t+1.
- Store: mem_ready in cycle k -> d_req_ready=1 in k+1 -> IDLE in k+2. Minimum store latency 3 cycles from valid to ready.
- Refill: last beat in cycle k -> req_ready in k+1. Beats may be non-contiguous; each beat appears on rdata_valid in the same cycle as mem_rvalid.
- mem_valid, mem_wr, mem_addr, mem_wdata are stable for all of REQ.
- Back-to-back: with both requesters continuously valid, grants alternate D, I, D, I...

## Test plan
- Single DCache store addr 0x1000_0004, wdata 0xDEAD_BEEF, mem_ready one cycle after mem_valid -> mem_addr 0x1000_0004, mem_wr=1, d_req_ready pulse exactly one cycle after mem_ready, i_* outputs 0.
- ICache refill addr 0x1C00_0018, LINE_WORDS=4, beats 0x11,0x22,0x33,0x44 with a 2-cycle gap after beat 2 -> mem_addr 0x1C00_0010, i_rdata_valid on exactly those 4 cycles with matching data, i_req_ready one cycle after beat 4.
- Simultaneous i/d requests out of reset -> DCache granted first, ICache next; with both held continuously, four transactions grant D, I, D, I.
- mem_ready held low 10 cycles -> mem_valid/addr/wdata stable all 10 cycles; stray mem_rvalid during REQ produces no rdata_valid.
- rst=0 in RDATA after 2 beats -> next cycle all outputs 0, state IDLE; remaining 2 beats produce no rdata_valid and no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between ICache line refills and DCache
// refills/stores, with round-robin arbitration on simultaneous requests.
module mem_port_arbiter #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  input  logic [WORD-1:0] i_req_addr,
  output logic            i_req_ready,
  output logic [WORD-1:0] i_rdata,
  output logic            i_rdata_valid,
  input  logic            d_req_valid,
  input  logic            d_req_wr,
  input  logic [WORD-1:0] d_req_addr,
  input  logic [WORD-1:0] d_req_wdata,
  output logic            d_req_ready,
  output logic [WORD-1:0] d_rdata,
  output logic            d_rdata_valid,
  output logic            mem_valid,
  output logic            mem_wr,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [WORD-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);
  localparam logic [WORD-1:0] LINE_MASK = ~WORD'(LINE_WORDS * WORD / 8 - 1);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, DONE} state_e;

  state_e           state_q, state_d;
  logic             gnt_d_q, gnt_d_d;   // 1 = DCache owns the port
  logic             last_d_q, last_d_d; // 1 = DCache won the previous grant
  logic             wr_q, wr_d;
  logic [WORD-1:0]  addr_q, addr_d;
  logic [WORD-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_d;

  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    pick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid || d_req_valid) begin
          // On a tie the DCache wins only if the ICache was served last
          pick_d   = d_req_valid && (!i_req_valid || !last_d_q);
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
          wr_d     = pick_d && d_req_wr;
          addr_d   = pick_d ? d_req_addr : i_req_addr;
          wdata_d  = pick_d ? d_req_wdata : '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d = wr_q ? DONE : RDATA;
          cnt_d   = '0;
        end
      end
      RDATA: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    mem_valid     = (state_q == REQ);
    mem_wr        = mem_valid && wr_q;
    mem_addr      = mem_valid ? (wr_q ? addr_q : (addr_q & LINE_MASK)) : '0;
    mem_wdata     = mem_valid ? wdata_q : '0;
    i_req_ready   = (state_q == DONE) && !gnt_d_q;
    d_req_ready   = (state_q == DONE) && gnt_d_q;
    i_rdata_valid = (state_q == RDATA) && mem_rvalid && !gnt_d_q;
    d_rdata_valid = (state_q == RDATA) && mem_rvalid && gnt_d_q;
    i_rdata       = mem_rdata;
    d_rdata       = mem_rdata;
  end

endmodule
